multi_timer: RTL and testbench

- N-channel programmable countdown timer; the multi-channel, multi-mode successor of the single-channel seconds timer.
- Each channel has:
  - its own load value and mode (one-shot or periodic);
  - pause, abort and retrigger;
  - a one-cycle done pulse.
- Sits beside the control FSMs; they use it for timeouts, blink rates and periodic events.
- Tick period derives from CLK_HZ/TICK_HZ, so no magic cycle counts live in the RTL.

---
 rtl/timer_pkg.sv | 25 ++
 rtl/timer_channel.sv | 110 +++++++++++
 rtl/multi_timer.sv | 66 ++++++
 tb/tb_multi_timer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel countdown timer.
//   MODE_ONESHOT / MODE_PERIODIC : per-channel mode encodings (mode_i bit)
//   tick_cycles()                : clk cycles per timer tick
//   tick_cfg_ok()                : elaboration-time sanity check of the clock/tick pair
package timer_pkg;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // Cycles per tick; a zero tick rate yields 0 so the config check can reject it
  // instead of elaboration dividing by zero.
  function automatic int tick_cycles(input int clk_hz, input int tick_hz);
    if (tick_hz <= 0) return 0;
    return clk_hz / tick_hz;
  endfunction

  // The tick period must be an exact whole number of clocks and at least two,
  // otherwise the prescaler cannot represent a wrap point.
  function automatic bit tick_cfg_ok(input int clk_hz, input int tick_hz);
    if (tick_hz <= 0 || clk_hz <= 0) return 1'b0;
    if ((clk_hz % tick_hz) != 0) return 1'b0;
    return (clk_hz / tick_hz) >= 2;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: start edge detect, tick prescaler, remaining-tick
// counter and one-shot/periodic reload.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : start level; a rising edge (re)loads the channel
//   mode       : 0 one-shot, 1 periodic; sampled on the start edge
//   delay      : tick count; sampled on the start edge
//   pause      : level; freezes prescaler and remain
//   abort      : level; returns the channel to idle without a done pulse
//   active     : channel running (paused included)
//   done       : one-cycle strobe on expiry (or one cycle after a zero-delay start)
//   remain     : registered remaining whole ticks, 0 when idle
// Interface note: there is no valid/ready handshake here. start is a plain
// level whose rising edge is the request; done is a single-cycle strobe that
// the consumer must sample in the cycle it is high.
module timer_channel
  import timer_pkg::*;
#(
  parameter int TICK_CYC = 10,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] delay,
  input  logic             pause,
  input  logic             abort,
  output logic             active,
  output logic             done,
  output logic [CNT_W-1:0] remain
);

  localparam int              PS_W    = $clog2(TICK_CYC);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_CYC - 1);

  logic             start_prev;
  logic             active_q;
  logic             done_q;
  logic [PS_W-1:0]  prescale_q;
  logic [CNT_W-1:0] remain_q;
  logic [CNT_W-1:0] d_q;
  logic             mode_q;

  logic start_edge;
  logic tick_wrap;
  logic expire;

  assign start_edge = start & ~start_prev;
  assign tick_wrap  = (prescale_q == PS_LAST);
  // remain is never 0 while active, so this is the 1 -> 0 transition.
  assign expire     = tick_wrap && (remain_q == CNT_W'(1));

  // Priority: rst > abort > start edge > pause > count. A start edge beats the
  // count branch, which is what suppresses an expiry landing on a retrigger.
  always_ff @(posedge clk) begin
    if (rst) begin
      // All ones so a start level held through reset is not seen as an edge.
      start_prev <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      prescale_q <= '0;
      remain_q   <= '0;
      d_q        <= '0;
      mode_q     <= MODE_ONESHOT;
    end else begin
      start_prev <= start;
      done_q     <= 1'b0;
      if (abort) begin
        active_q   <= 1'b0;
        prescale_q <= '0;
        remain_q   <= '0;
      end else if (start_edge) begin
        d_q        <= delay;
        mode_q     <= mode;
        prescale_q <= '0;
        remain_q   <= delay;
        if (delay == '0) begin
          // Nothing to count: report completion immediately, never go active.
          active_q <= 1'b0;
          done_q   <= 1'b1;
        end else begin
          active_q <= 1'b1;
        end
      end else if (active_q && !pause) begin
        if (tick_wrap) begin
          prescale_q <= '0;
          if (expire) begin
            done_q <= 1'b1;
            if (mode_q == MODE_PERIODIC) begin
              remain_q <= d_q;
            end else begin
              remain_q <= '0;
              active_q <= 1'b0;
            end
          end else begin
            remain_q <= remain_q - CNT_W'(1);
          end
        end else begin
          prescale_q <= prescale_q + PS_W'(1);
        end
      end
    end
  end

  assign active = active_q;
  assign done   = done_q;
  assign remain = remain_q;

endmodule

// File: rtl/multi_timer.sv
// N-channel programmable countdown timer. Each channel is an independent
// timer_channel; this level only checks the configuration and slices the
// packed per-channel vectors.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start_i   : [N_CH] start levels (rising edge triggers)
//   mode_i    : [N_CH] 0 one-shot, 1 periodic
//   delay_i   : [N_CH*CNT_W] tick counts, channel c at [c*CNT_W +: CNT_W]
//   pause_i   : [N_CH] freeze levels
//   abort_i   : [N_CH] abort levels
//   active_o  : [N_CH] channel running
//   done_o    : [N_CH] expiry strobes
//   remain_o  : [N_CH*CNT_W] remaining ticks, same packing as delay_i
module multi_timer
  import timer_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1,
  parameter int N_CH    = 4,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       start_i,
  input  logic [N_CH-1:0]       mode_i,
  input  logic [N_CH*CNT_W-1:0] delay_i,
  input  logic [N_CH-1:0]       pause_i,
  input  logic [N_CH-1:0]       abort_i,
  output logic [N_CH-1:0]       active_o,
  output logic [N_CH-1:0]       done_o,
  output logic [N_CH*CNT_W-1:0] remain_o
);

  localparam int TICK_CYC = tick_cycles(CLK_HZ, TICK_HZ);

  if (!tick_cfg_ok(CLK_HZ, TICK_HZ)) begin : g_bad_tick_cfg
    $error("multi_timer: CLK_HZ must be a multiple of TICK_HZ with CLK_HZ/TICK_HZ >= 2");
  end

  if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
    $error("multi_timer: N_CH must be in 1..16");
  end

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("multi_timer: CNT_W must be at least 1");
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    timer_channel #(
      .TICK_CYC (TICK_CYC),
      .CNT_W    (CNT_W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .start  (start_i[c]),
      .mode   (mode_i[c]),
      .delay  (delay_i[c*CNT_W +: CNT_W]),
      .pause  (pause_i[c]),
      .abort  (abort_i[c]),
      .active (active_o[c]),
      .done   (done_o[c]),
      .remain (remain_o[c*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_multi_timer.sv
module tb_multi_timer;

  localparam int CLK_HZ  = 10;
  localparam int TICK_HZ = 1;
  localparam int T       = CLK_HZ / TICK_HZ;
  localparam int N_CH    = 4;
  localparam int CNT_W   = 8;
  localparam int EXP_W   = 2 * N_CH + N_CH * CNT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [N_CH-1:0]       start_i;
  logic [N_CH-1:0]       mode_i;
  logic [N_CH*CNT_W-1:0] delay_i;
  logic [N_CH-1:0]       pause_i;
  logic [N_CH-1:0]       abort_i;
  logic [N_CH-1:0]       active_o;
  logic [N_CH-1:0]       done_o;
  logic [N_CH*CNT_W-1:0] remain_o;

  multi_timer #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ),
    .N_CH    (N_CH),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .mode_i   (mode_i),
    .delay_i  (delay_i),
    .pause_i  (pause_i),
    .abort_i  (abort_i),
    .active_o (active_o),
    .done_o   (done_o),
    .remain_o (remain_o)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int ch0_done_cyc = -1;

  // ---------------- reference model ----------------
  // Each channel is described by how many unpaused cycles it has counted since
  // its last (re)load; expiry is when that reaches D*T, and the remaining whole
  // ticks are D minus the completed ticks.
  int m_run[N_CH];
  int m_d[N_CH];
  int m_per[N_CH];
  int m_el[N_CH];
  int m_prev[N_CH];

  function automatic logic [EXP_W-1:0] model_step();
    logic [N_CH-1:0]       act;
    logic [N_CH-1:0]       dn;
    logic [N_CH*CNT_W-1:0] rem;
    act = '0;
    dn  = '0;
    rem = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (rst) begin
        m_run[c]  = 0;
        m_d[c]    = 0;
        m_per[c]  = 0;
        m_el[c]   = 0;
        m_prev[c] = 1;
      end else begin
        int new_d;
        bit edge_seen;
        new_d     = int'(delay_i[c*CNT_W +: CNT_W]);
        edge_seen = start_i[c] && (m_prev[c] == 0);
        m_prev[c] = start_i[c] ? 1 : 0;
        if (abort_i[c]) begin
          m_run[c] = 0;
        end else if (edge_seen) begin
          if (new_d == 0) begin
            m_run[c] = 0;
            dn[c]    = 1'b1;
          end else begin
            m_run[c] = 1;
            m_d[c]   = new_d;
            m_per[c] = mode_i[c] ? 1 : 0;
            m_el[c]  = 0;
          end
        end else if (m_run[c] != 0 && !pause_i[c]) begin
          m_el[c] = m_el[c] + 1;
          if (m_el[c] == m_d[c] * T) begin
            dn[c]   = 1'b1;
            m_el[c] = 0;
            if (m_per[c] == 0) m_run[c] = 0;
          end
        end
      end
      act[c] = (m_run[c] != 0);
      if (m_run[c] != 0) rem[c*CNT_W +: CNT_W] = CNT_W'(m_d[c] - m_el[c] / T);
    end
    return {act, dn, rem};
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge with inputs already set for the coming rising edge.
  task automatic next_cycle();
    exp_q.push_back(model_step());
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) next_cycle();
  endtask

  task automatic set_delay(input int c, input int d);
    delay_i[c*CNT_W +: CNT_W] = CNT_W'(d);
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [EXP_W-1:0] e;
        logic [N_CH-1:0]       e_act;
        logic [N_CH-1:0]       e_dn;
        logic [N_CH*CNT_W-1:0] e_rem;
        e = exp_q.pop_front();
        {e_act, e_dn, e_rem} = e;
        n_cmp = n_cmp + 3;
        if (active_o !== e_act) begin
          n_fail++;
          $display("FAIL active cyc=%0d got=%b exp=%b", cyc, active_o, e_act);
        end
        if (done_o !== e_dn) begin
          n_fail++;
          $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done_o, e_dn);
        end
        if (remain_o !== e_rem) begin
          n_fail++;
          $display("FAIL remain cyc=%0d got=%h exp=%h", cyc, remain_o, e_rem);
        end
      end
      if (done_o[0] === 1'b1 && ch0_done_cyc < 0) ch0_done_cyc = cyc;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int start_cyc;
    rst     = 1'b1;
    start_i = '0;
    mode_i  = '0;
    delay_i = '0;
    pause_i = '0;
    abort_i = '0;
    @(negedge clk);

    // Start held high through reset release must not trigger.
    start_i = 4'b0001;
    set_delay(0, 2);
    run(3);
    rst = 1'b0;
    run(15);
    start_i = '0;
    run(2);

    // One-shot ch0, D=3; done expected 30 edges after the start edge.
    ch0_done_cyc = -1;
    set_delay(0, 3);
    mode_i[0]  = 1'b0;
    start_i[0] = 1'b1;
    start_cyc  = cyc + 1;
    run(1);
    start_i[0] = 1'b0;
    run(40);
    n_cmp++;
    if (ch0_done_cyc != start_cyc + 3 * T) begin
      n_fail++;
      $display("FAIL oneshot_done_cycle got=%0d exp=%0d", ch0_done_cyc, start_cyc + 3 * T);
    end

    // Periodic ch1, D=2, five periods then abort.
    set_delay(1, 2);
    mode_i[1]  = 1'b1;
    start_i[1] = 1'b1;
    run(1);
    start_i[1] = 1'b0;
    run(5 * 2 * T + 5);
    abort_i[1] = 1'b1;
    run(1);
    abort_i[1] = 1'b0;
    run(30);

    // Pause ch2 mid-tick for 7 cycles.
    set_delay(2, 2);
    mode_i[2]  = 1'b0;
    start_i[2] = 1'b1;
    run(1);
    start_i[2] = 1'b0;
    run(15);
    pause_i[2] = 1'b1;
    run(7);
    pause_i[2] = 1'b0;
    run(30);

    // Retrigger ch3: D=5, restarted at 30 cycles with D=1.
    set_delay(3, 5);
    mode_i[3]  = 1'b0;
    start_i[3] = 1'b1;
    run(1);
    start_i[3] = 1'b0;
    run(29);
    set_delay(3, 1);
    start_i[3] = 1'b1;
    run(1);
    start_i[3] = 1'b0;
    run(20);

    // Zero delay start: done next cycle, never active.
    set_delay(3, 0);
    start_i[3] = 1'b1;
    run(1);
    start_i[3] = 1'b0;
    run(5);

    // Reset in the middle of a count.
    set_delay(0, 4);
    start_i[0] = 1'b1;
    run(1);
    start_i[0] = 1'b0;
    run(15);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(3);

    // Abort and start together: abort wins.
    set_delay(1, 2);
    abort_i[1] = 1'b1;
    start_i[1] = 1'b1;
    run(1);
    abort_i[1] = 1'b0;
    start_i[1] = 1'b0;
    run(3);

    // All channels expire in the same cycle.
    for (int c = 0; c < N_CH; c++) set_delay(c, 1);
    mode_i  = '0;
    start_i = '1;
    run(1);
    start_i = '0;
    run(15);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 999) == 0);
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 39) == 0) start_i[c] = ~start_i[c];
        if ($urandom_range(0, 19) == 0) pause_i[c] = ~pause_i[c];
        abort_i[c] = ($urandom_range(0, 199) == 0);
        mode_i[c]  = 1'($urandom_range(0, 1));
        set_delay(c, int'($urandom_range(0, 3)));
      end
      run(1);
    end
    rst     = 1'b0;
    start_i = '0;
    pause_i = '0;
    abort_i = '0;
    run(5);

    // Let the monitor drain the queue, bounded.
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain left=%0d exp=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
